spi_bus_arbiter: RTL and testbench
==================================

// Module: spi_bus_arbiter
// PURPOSE
//  Shares one spi_master among NUM_REQ requesters (e.g. sensor, flash, config FSMs).
//  Round-robin arbitration; per-grant CPOL/CPHA and TX byte; launches one 8-bit
//  transfer; returns the MISO byte with an ack pulse. Adds a watchdog on a stuck master.
//  Sits between the requester logic and spi_master; the spi_master ports connect 1:1 to m_*.
// PARAMETERS
//  NUM_REQ   4    number of requesters, 2..8
//  TIMEOUT   255  max clk cycles in WAIT before abort, 1..65535
// PORTS
//  clk          in   1          system clock, all logic on rising edge
//  rst          in   1          synchronous, active-high reset
//  req          in   NUM_REQ    request; held high until own ack
//  req_data     in   8*NUM_REQ  TX byte; requester i uses bits [8i+7:8i]
//  req_cpol     in   NUM_REQ    SPI mode CPOL per requester
//  req_cpha     in   NUM_REQ    SPI mode CPHA per requester
//  grant        out  NUM_REQ    one-hot current owner, 0 when idle
//  ack          out  NUM_REQ    one-cycle completion pulse to owner
//  rsp_data     out  8          received byte, valid in ack cycle
//  rsp_err      out  1          error flag, valid in ack cycle
//  m_start      out  1          to spi_master start, one-cycle pulse
//  m_mosi_data  out  8          to spi_master mosi_data
//  m_cpol       out  1          to spi_master cpol
//  m_cpha       out  1          to spi_master cpha
//  m_miso_data  in   8          from spi_master miso_data
//  m_done       in   1          from spi_master done
//  m_busy       in   1          from spi_master busy
//  m_error      in   1          from spi_master error
// BEHAVIOUR
//  Reset: state IDLE; grant, ack, m_start, rsp_err = 0; rsp_data, m_mosi_data = 0;
//   m_cpol = m_cpha = 0; timer = 0; last_owner = NUM_REQ-1 (req[0] wins first).
//  FSM IDLE -> LAUNCH -> WAIT -> DONE -> IDLE.
//  IDLE: if |req && !m_busy: owner = first set req scanning last_owner+1 upward, wrapping
//   mod NUM_REQ; register grant, m_mosi_data, m_cpol, m_cpha from owner; -> LAUNCH.
//   If m_busy is high, no grant occurs.
//  LAUNCH: m_start = 1 for exactly this cycle; timer = 0; -> WAIT.
//  WAIT: timer increments each cycle. m_done -> rsp_data = m_miso_data,
//   rsp_err = m_error; -> DONE. Else if timer == TIMEOUT-1 -> rsp_data = 0,
//   rsp_err = 1; -> DONE. m_done and timeout in the same cycle: m_done wins.
//  DONE: ack[owner] = 1 for one cycle; rsp_* valid; grant = 0;
//   last_owner = owner; -> IDLE. rsp_* hold until the next DONE.
//  Latency: req sampled in IDLE at cycle t -> m_start at t+1. Ack is 1 cycle
//   after m_done. A back-to-back grant occurs no earlier than 1 cycle after ack.
//  m_mosi_data, m_cpol and m_cpha are stable from LAUNCH through DONE. They change
//   only on a grant.
//  req[owner] dropping mid-transfer does not abort; the ack is still pulsed.
//  Changes to req_data or mode after the grant are ignored.
//  Fairness: with all req high, grants rotate 0,1,..,N-1,0; no starvation.
//  rst mid-transfer returns to the reset state next edge; the master is reset
//   by the same rst.
//  ack and grant are never non-zero for a non-owner. At most one ack bit is set.
// TESTING
//  1 req[0], data 8'hAA, mode 0, slave tx 8'hCC -> m_start 1 cycle later;
//    ack[0] pulse, rsp_data = 8'hCC, rsp_err = 0.
//  2 all four req high, held -> grant order 0,1,2,3,0; each ack carries its slave byte.
//  3 req[2] cpol=1 cpha=1, then req[1] cpol=0 cpha=0 -> m_cpol/m_cpha switch only
//    at the second grant; both bytes correct.
//  4 m_done held low, TIMEOUT=16 -> ack 17 cycles after m_start; rsp_err = 1, rsp_data = 0.
//  5 m_error and m_done together -> rsp_err = 1, rsp_data = m_miso_data.
//  6 rst asserted in WAIT -> all outputs reach reset values next edge; next req[0]
//    is served first and the transfer completes.

Source files
------------

// File: rtl/spi_bus_arbiter.sv
// spi_bus_arbiter: round-robin sharing of one spi_master among NUM_REQ requesters.
// Each grant captures the owner's TX byte and SPI mode, launches one transfer,
// waits for done (or a watchdog timeout) and returns the result with an ack pulse.
module spi_bus_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_cpol,
  input  logic [NUM_REQ-1:0]     req_cpha,
  output logic [NUM_REQ-1:0]     grant,
  output logic [NUM_REQ-1:0]     ack,
  output logic [7:0]             rsp_data,
  output logic                   rsp_err,
  output logic                   m_start,
  output logic [7:0]             m_mosi_data,
  output logic                   m_cpol,
  output logic                   m_cpha,
  input  logic [7:0]             m_miso_data,
  input  logic                   m_done,
  input  logic                   m_busy,
  input  logic                   m_error
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);

  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  idx_t                 owner_q, owner_d;
  idx_t                 last_q, last_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [7:0]           mosi_q, mosi_d;
  logic                 cpol_q, cpol_d;
  logic                 cpha_q, cpha_d;
  logic [7:0]           rsp_data_q, rsp_data_d;
  logic                 rsp_err_q, rsp_err_d;
  logic [15:0]          timer_q, timer_d;

  logic                 pick_valid;
  idx_t                 pick;
  idx_t                 cand;

  // Round-robin pick: first active request scanning upward from last_owner+1.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    pick_valid = 1'b0;
    pick       = '0;
    cand       = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = idx_t'((int'(last_q) + off) % NUM_REQ);
      if (!pick_valid && req[cand]) begin
        pick_valid = 1'b1;
        pick       = cand;
      end
    end
  end

  // Next-state and next-register logic for the transfer sequence.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    grant_d    = grant_q;
    mosi_d     = mosi_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    timer_d    = timer_q;

    case (state_q)
      S_IDLE: begin
        // A busy master (e.g. still finishing after a reset race) blocks new grants.
        if (pick_valid && !m_busy) begin
          owner_d       = pick;
          grant_d       = '0;
          grant_d[pick] = 1'b1;
          mosi_d        = req_data[8*int'(pick) +: 8];
          cpol_d        = req_cpol[pick];
          cpha_d        = req_cpha[pick];
          state_d       = S_LAUNCH;
        end
      end

      S_LAUNCH: begin
        timer_d = '0;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        timer_d = timer_q + 16'd1;
        // A done arriving on the last watchdog cycle still counts as a completion.
        if (m_done) begin
          rsp_data_d = m_miso_data;
          rsp_err_d  = m_error;
          state_d    = S_DONE;
        end else if (timer_q == TIMER_LAST) begin
          rsp_data_d = 8'h00;
          rsp_err_d  = 1'b1;
          state_d    = S_DONE;
        end
      end

      S_DONE: begin
        grant_d = '0;
        last_d  = owner_q;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q    <= S_IDLE;
      owner_q    <= '0;
      last_q     <= idx_t'(NUM_REQ - 1);
      grant_q    <= '0;
      mosi_q     <= 8'h00;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      rsp_data_q <= 8'h00;
      rsp_err_q  <= 1'b0;
      timer_q    <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      grant_q    <= grant_d;
      mosi_q     <= mosi_d;
      cpol_q     <= cpol_d;
      cpha_q     <= cpha_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      timer_q    <= timer_d;
    end
  end

  assign grant       = grant_q;
  assign ack         = (state_q == S_DONE) ? grant_q : '0;
  assign m_start     = (state_q == S_LAUNCH);
  assign m_mosi_data = mosi_q;
  assign m_cpol      = cpol_q;
  assign m_cpha      = cpha_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_err     = rsp_err_q;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Testbench for spi_bus_arbiter: directed scenarios plus randomized traffic,
// checked against a round-robin model of the requesters and a behavioural master.
module tb_spi_bus_arbiter;

  localparam int N  = 4;
  localparam int TO = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req;
  logic [8*N-1:0]   req_data;
  logic [N-1:0]     req_cpol;
  logic [N-1:0]     req_cpha;
  logic [N-1:0]     grant;
  logic [N-1:0]     ack;
  logic [7:0]       rsp_data;
  logic             rsp_err;
  logic             m_start;
  logic [7:0]       m_mosi_data;
  logic             m_cpol;
  logic             m_cpha;
  logic [7:0]       m_miso_data;
  logic             m_done;
  logic             m_busy;
  logic             m_error;

  spi_bus_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_data    (req_data),
    .req_cpol    (req_cpol),
    .req_cpha    (req_cpha),
    .grant       (grant),
    .ack         (ack),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err),
    .m_start     (m_start),
    .m_mosi_data (m_mosi_data),
    .m_cpol      (m_cpol),
    .m_cpha      (m_cpha),
    .m_miso_data (m_miso_data),
    .m_done      (m_done),
    .m_busy      (m_busy),
    .m_error     (m_error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Requester model: pending flag and the byte/mode each requester presents.
  bit         pend  [N];
  logic [7:0] pdata [N];
  bit         pcpol [N];
  bit         pcpha [N];
  int         model_last;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Owner = pending requester at the smallest circular distance after the last owner.
  function automatic int model_pick();
    int best;
    int best_dist;
    int d;
    best      = -1;
    best_dist = N + 1;
    for (int i = 0; i < N; i++) begin
      if (pend[i]) begin
        d = (i - model_last - 1 + 2 * N) % N;
        if (d < best_dist) begin
          best_dist = d;
          best      = i;
        end
      end
    end
    return best;
  endfunction

  task automatic drive_reqs();
    for (int i = 0; i < N; i++) begin
      req[i]            = pend[i];
      req_data[8*i +: 8] = pdata[i];
      req_cpol[i]       = pcpol[i];
      req_cpha[i]       = pcpha[i];
    end
  endtask

  task automatic set_req(input int i, input logic [7:0] d, input bit cp, input bit ch);
    pend[i]  = 1'b1;
    pdata[i] = d;
    pcpol[i] = cp;
    pcpha[i] = ch;
    drive_reqs();
  endtask

  task automatic check_reset_outputs(input string tag);
    check(tag, 32'({grant, ack, m_start, rsp_err, rsp_data, m_mosi_data, m_cpol, m_cpha}), 32'd0);
  endtask

  task automatic reset_dut();
    rst         = 1'b1;
    m_done      = 1'b0;
    m_busy      = 1'b0;
    m_error     = 1'b0;
    m_miso_data = 8'h00;
    for (int i = 0; i < N; i++) begin
      pend[i]  = 1'b0;
      pdata[i] = 8'h00;
      pcpol[i] = 1'b0;
      pcpha[i] = 1'b0;
    end
    drive_reqs();
    repeat (2) @(negedge clk);
    check_reset_outputs("reset_state");
    rst        = 1'b0;
    model_last = N - 1;
  endtask

  // One complete transfer, entered and left at a negedge with the arbiter idle.
  // lat: cycles after m_start at which the master reports done (1..TO).
  task automatic run_txn(input logic [7:0] miso, input int lat, input bit err,
                         input bit hang, input bit mutate);
    int         own;
    int         w;
    int         ack_k;
    logic [7:0] ed;
    bit         ec;
    bit         eh;
    logic [N-1:0] oh;
    logic [7:0] exp_rsp;
    bit         exp_err;

    own = model_pick();
    if (own < 0) return;
    ed = pdata[own];
    ec = pcpol[own];
    eh = pcpha[own];
    oh = '0;
    oh[own] = 1'b1;
    exp_rsp = hang ? 8'h00 : miso;
    exp_err = hang ? 1'b1 : err;

    w = 0;
    for (int t = 1; t <= 4; t++) begin
      @(negedge clk);
      if (m_start) begin
        w = t;
        break;
      end
    end
    check("start_latency", 32'(w), 32'd1);
    if (w == 0) return;
    check("grant", 32'(grant), 32'(oh));
    check("launch_cfg", 32'({m_mosi_data, m_cpol, m_cpha}), 32'({ed, ec, eh}));
    m_busy = 1'b1;
    m_done = 1'b0;

    ack_k = 0;
    for (int kk = 1; kk <= TO + 3; kk++) begin
      @(negedge clk);
      if (ack != '0) begin
        ack_k = kk;
        break;
      end
      check("wait_hold", 32'({m_start, m_mosi_data, m_cpol, m_cpha, grant}),
            32'({1'b0, ed, ec, eh, oh}));
      if (mutate && kk == 1) begin
        pdata[own] = ~pdata[own];
        pcpol[own] = ~pcpol[own];
        pcpha[own] = ~pcpha[own];
        pend[own]  = 1'b0;
        drive_reqs();
      end
      if (!hang && kk == lat) begin
        m_done      = 1'b1;
        m_miso_data = miso;
        m_error     = err;
      end else begin
        m_done      = 1'b0;
        m_miso_data = 8'($urandom);
        m_error     = 1'($urandom);
      end
    end
    check("ack_latency", 32'(ack_k), hang ? 32'(TO + 1) : 32'(lat + 1));
    check("ack", 32'(ack), 32'(oh));
    check("rsp_data", 32'(rsp_data), 32'(exp_rsp));
    check("rsp_err", 32'(rsp_err), 32'(exp_err));
    check("done_cfg", 32'({m_mosi_data, m_cpol, m_cpha}), 32'({ed, ec, eh}));

    m_done    = 1'b0;
    m_busy    = 1'b0;
    m_error   = 1'b0;
    pend[own] = 1'b0;
    drive_reqs();
    model_last = own;

    @(negedge clk);
    check("idle_after_ack", 32'({ack, grant, m_start}), 32'd0);
    check("rsp_hold", 32'({rsp_data, rsp_err}), 32'({exp_rsp, exp_err}));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "simulation time limit exceeded");
  end

  initial begin
    bit any;
    bit hang;
    int pick;

    reset_dut();

    // Single transfer from requester 0.
    set_req(0, 8'hAA, 1'b0, 1'b0);
    run_txn(8'hCC, 3, 1'b0, 1'b0, 1'b0);

    // Mode switch between two consecutive grants.
    set_req(2, 8'h3C, 1'b1, 1'b1);
    run_txn(8'h11, 5, 1'b0, 1'b0, 1'b0);
    set_req(1, 8'hC3, 1'b0, 1'b0);
    run_txn(8'h22, 2, 1'b0, 1'b0, 1'b0);

    // Stuck master: watchdog abort.
    set_req(3, 8'h77, 1'b0, 1'b1);
    run_txn(8'hFF, 1, 1'b0, 1'b1, 1'b0);

    // Error reported together with done.
    set_req(0, 8'h01, 1'b1, 1'b0);
    run_txn(8'h9E, 4, 1'b1, 1'b0, 1'b0);

    // Done on the final watchdog cycle wins over the timeout.
    set_req(1, 8'h42, 1'b1, 1'b0);
    run_txn(8'h66, TO, 1'b0, 1'b0, 1'b0);

    // Busy master blocks a grant.
    m_busy = 1'b1;
    set_req(3, 8'h5F, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("busy_blocks", 32'({grant, m_start}), 32'd0);
    end
    m_busy = 1'b0;
    run_txn(8'hA5, 2, 1'b0, 1'b0, 1'b0);

    // Owner drops req and changes its data/mode mid-transfer.
    set_req(2, 8'h81, 1'b1, 1'b0);
    run_txn(8'h3E, 6, 1'b0, 1'b0, 1'b1);

    // Reset in the middle of a transfer.
    set_req(1, 8'h5A, 1'b1, 1'b0);
    for (int t = 1; t <= 4; t++) begin
      @(negedge clk);
      if (m_start) break;
    end
    check("mid_rst_start", 32'(m_start), 32'd1);
    m_busy = 1'b1;
    repeat (3) @(negedge clk);
    rst    = 1'b1;
    m_busy = 1'b0;
    m_done = 1'b0;
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    drive_reqs();
    @(negedge clk);
    check_reset_outputs("mid_rst_state");
    rst        = 1'b0;
    model_last = N - 1;
    set_req(2, 8'h24, 1'b0, 1'b1);
    set_req(0, 8'h18, 1'b1, 1'b1);
    run_txn(8'hB7, 3, 1'b0, 1'b0, 1'b0);
    run_txn(8'h7B, 2, 1'b0, 1'b0, 1'b0);

    // Fairness: all four held, requester 0 re-requests after its ack.
    reset_dut();
    for (int i = 0; i < N; i++) set_req(i, 8'(8'h10 + i), 1'(i & 1), 1'(i >> 1));
    run_txn(8'hE0, 2, 1'b0, 1'b0, 1'b0);
    set_req(0, 8'h99, 1'b1, 1'b1);
    run_txn(8'hE1, 3, 1'b0, 1'b0, 1'b0);
    run_txn(8'hE2, 1, 1'b0, 1'b0, 1'b0);
    run_txn(8'hE3, 4, 1'b0, 1'b0, 1'b0);
    run_txn(8'hE4, 2, 1'b0, 1'b0, 1'b0);

    // Randomized traffic.
    for (int it = 0; it < 60; it++) begin
      any = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
          pend[i]  = 1'b1;
          pdata[i] = 8'($urandom);
          pcpol[i] = 1'($urandom);
          pcpha[i] = 1'($urandom);
        end
        if (pend[i]) any = 1'b1;
      end
      if (!any) begin
        pick        = int'($urandom_range(0, N - 1));
        pend[pick]  = 1'b1;
        pdata[pick] = 8'($urandom);
        pcpol[pick] = 1'($urandom);
        pcpha[pick] = 1'($urandom);
      end
      drive_reqs();
      hang = ($urandom_range(0, 7) == 0);
      run_txn(8'($urandom), int'($urandom_range(1, TO)), ($urandom_range(0, 3) == 0),
              hang, ($urandom_range(0, 3) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
